// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: funct codes shared with the ALU and the multiply/divide FSM states
package mult_div_unit_pkg;

    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide with architectural HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div_q, div_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        dz_q, dz_d;
    logic        done_q;

    logic        idle_start, is_signed, is_div, accept;
    logic [32:0] mul_sum, div_diff;
    logic [63:0] step, prod;

    assign idle_start = start && state_q == IDLE;
    assign is_signed  = funct == ALU_MULT || funct == ALU_DIV;
    assign is_div     = funct == ALU_DIV || funct == ALU_DIVU;
    assign accept     = idle_start && (is_div || funct == ALU_MULT || funct == ALU_MULTU);

    // Multiply adds the multiplicand into the top half when the current multiplier bit
    // is set, then shifts right keeping the carry. Divide shifts left and subtracts the
    // divisor from the partial remainder when it fits, shifting in the quotient bit.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
    assign div_diff = acc_q[63:31] - {1'b0, mag_q};
    assign step     = div_q ? (div_diff[32] ? {acc_q[62:0], 1'b0} : {div_diff[31:0], acc_q[30:0], 1'b1})
                            : {mul_sum, acc_q[31:1]};
    assign prod     = (s1_q ^ s2_q) ? -acc_q : acc_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: 32 CALC iterations then a single FIX cycle
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)      state_d = accept ? CALC : IDLE;
        else if (state_q == CALC) state_d = count_q == 5'd31 ? FIX : CALC;
        else                      state_d = IDLE;
    end

    // Outputs: busy follows the state, done is the registered FIX indication
    always_comb begin
        busy = state_q != IDLE;
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath next values. A zero divisor leaves the raw all-ones quotient and a remainder
    // equal to the dividend magnitude, so restoring the dividend sign yields operand1 exactly.
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        mag_d   = mag_q;
        div_d   = div_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (idle_start && funct == ALU_MTHI) hi_d = operand1;
        if (idle_start && funct == ALU_MTLO) lo_d = operand1;
        if (accept) begin
            s1_d    = is_signed && operand1[31];
            s2_d    = is_signed && operand2[31];
            acc_d   = {32'd0, (is_signed && operand1[31]) ? -operand1 : operand1};
            mag_d   = (is_signed && operand2[31]) ? -operand2 : operand2;
            div_d   = is_div;
            dz_d    = operand2 == 32'd0;
            count_d = 5'd0;
        end
        if (state_q == CALC) begin
            acc_d   = step;
            count_d = count_q + 5'd1;
        end
        if (state_q == FIX) begin
            hi_d = div_q ? (s1_q ? -acc_q[63:32] : acc_q[63:32]) : prod[63:32];
            lo_d = div_q ? ((s1_q ^ s2_q) && !dz_q ? -acc_q[31:0] : acc_q[31:0]) : prod[31:0];
        end
    end

    // Datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= 64'd0;
            count_q <= 5'd0;
            mag_q   <= 32'd0;
            div_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            mag_q   <= mag_d;
            div_q   <= div_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= state_q == FIX;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for the multiply/divide unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          vectors = 0;
    int          miscompares = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .operand1(operand1), .operand2(operand2),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inj);
        int n = 0;
        funct = f; operand1 = a; operand2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && n < 100) begin
            n++;
            if (inj && n == 5) begin
                start = 1'b1; funct = ALU_MULTU; operand1 = 32'd2; operand2 = 32'd3;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " busy cycles"}, n, 33);
        chk({tag, " done"}, {31'd0, done}, 1);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        @(negedge clk);
        chk({tag, " done drop"}, {31'd0, done}, 0);
    endtask

    initial begin
        int pulses = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu max", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult -3*7", ALU_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("mult min*min", ALU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
        run_op("div -7/2", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div 7/-2", ALU_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
        run_op("divu 100/0", ALU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 0);
        run_op("div -5/0", ALU_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        run_op("div min/-1", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op("divu 100/7 inj", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1);
        chk("after inj busy", {31'd0, busy}, 0);

        funct = ALU_MTHI; operand1 = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        chk("mthi hi", hi, 32'hDEADBEEF);
        chk("mthi lo hold", lo, 32'd14);
        chk("mthi busy", {31'd0, busy}, 0);
        chk("mthi done", {31'd0, done}, 0);
        funct = ALU_MTLO; operand1 = 32'h12345678;
        @(negedge clk);
        chk("mtlo lo", lo, 32'h12345678);
        chk("mtlo hi hold", hi, 32'hDEADBEEF);
        chk("mtlo busy", {31'd0, busy}, 0);
        funct = ALU_MFHI; operand1 = 32'h55555555;
        @(negedge clk);
        chk("other funct hi", hi, 32'hDEADBEEF);
        chk("other funct lo", lo, 32'h12345678);
        chk("other funct busy", {31'd0, busy}, 0);
        chk("other funct done", {31'd0, done}, 0);

        funct = ALU_MULT; operand1 = 32'd9; operand2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-abort busy", {31'd0, busy}, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort done pulses", pulses, 0);
        chk("abort busy after", {31'd0, busy}, 0);
        chk("abort hi after", hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
